// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register file and its neighbours.
//   RF_DATA_W / RF_ADDR_W : default datapath width and address width,
//                           also used by the ALU and the control unit.
//   rf_state_e            : state of the bulk-clear sequencer.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/dec_n.sv
// dec_n: parametrised binary-to-one-hot decoder.
//   sel    [N-1:0]    : binary index
//   onehot [2**N-1:0] : bit sel set, all others clear
module dec_n #(
  parameter int N = 3
) (
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/rf_clear_fsm.sv
// rf_clear_fsm: sequencer that sweeps every register-file entry to zero.
//   clk, reset : clock, synchronous active-high reset
//   clr_req    : start a sweep (sampled only while idle)
//   busy       : registered, high for exactly 2**ADDR_W cycles per sweep
//   ptr        : entry cleared at the coming edge while sweeping
//   state      : current state; RF_CLEAR doubles as the clear enable
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] ptr,
  output rf_state_e         state
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RF_IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (clr_req) begin
            state <= RF_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          // clr_req is deliberately not looked at here: no restart, no queueing.
          ptr <= ptr + ADDR_W'(1);
          // Leave on the last entry so the wrapped pointer never starts a new pass.
          if (ptr == LAST) begin
            state <= RF_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RF_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file_param.sv
// register_file_param: 2**ADDR_W x DATA_W register file, one write port,
// two registered read ports with write-first bypass, optional zero r0 and
// a sequenced bulk clear.
//   clk, reset       : clock, synchronous active-high reset
//   W, W_Adr         : write data / address
//   we_pulse         : write enable (ignored while busy)
//   R_Adr, S_Adr     : read addresses, data appears on R/S one cycle later
//   clr_req          : start a bulk clear
//   R, S             : registered read data
//   busy             : clear sweep in progress, writes are dropped
// Handshake: there is no back-pressure on writes; a producer must keep
// we_pulse low while busy=1, any write offered then is discarded.
module register_file_param
  import rf_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] W,
  input  logic [ADDR_W-1:0] W_Adr,
  input  logic              we_pulse,
  input  logic [ADDR_W-1:0] R_Adr,
  input  logic [ADDR_W-1:0] S_Adr,
  input  logic              clr_req,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] S,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  rf_state_e         fsm_state;
  logic              clearing;
  logic              wr_ok;
  logic [DEPTH-1:0]  wr_onehot;
  logic [DEPTH-1:0]  clr_onehot;
  logic [DATA_W-1:0] r_next;
  logic [DATA_W-1:0] s_next;

  rf_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .busy    (busy),
    .ptr     (clr_ptr),
    .state   (fsm_state)
  );

  dec_n #(.N(ADDR_W)) u_wr_dec  (.sel(W_Adr),   .onehot(wr_onehot));
  dec_n #(.N(ADDR_W)) u_clr_dec (.sel(clr_ptr), .onehot(clr_onehot));

  assign clearing = (fsm_state == RF_CLEAR);

  // A write to r0 is discarded when r0 is hard-wired, so it can never bypass.
  always_comb begin
    wr_ok = we_pulse && !busy && !((ZERO_R0 != 0) && (W_Adr == '0));
  end

  // Hard-wired zero wins over bypass, bypass wins over the stored value.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] adr);
    if ((ZERO_R0 != 0) && (adr == '0))
      return '0;
    else if (wr_ok && (W_Adr == adr))
      return W;
    else
      return mem[adr];
  endfunction

  always_comb begin
    r_next = read_port(R_Adr);
    s_next = read_port(S_Adr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      R <= '0;
      S <= '0;
    end else begin
      // Writes are blocked while clearing, so the two enables never overlap.
      for (int i = 0; i < DEPTH; i++) begin
        if (clearing && clr_onehot[i])
          mem[i] <= '0;
        else if (wr_ok && wr_onehot[i])
          mem[i] <= W;
      end
      R <= r_next;
      S <= s_next;
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
module tb_register_file_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // group 0 drives dut_a (ZERO_R0=0) and dut_z (ZERO_R0=1), 16x8
  logic [15:0] w0 = '0;
  logic [2:0]  wa0 = '0, ra0 = '0, sa0 = '0;
  logic        we0 = 1'b0, clr0 = 1'b0;
  // group 1 drives dut_w, 32x32
  logic [31:0] w1 = '0;
  logic [4:0]  wa1 = '0, ra1 = '0, sa1 = '0;
  logic        we1 = 1'b0, clr1 = 1'b0;

  logic [15:0] r_a, s_a, r_z, s_z;
  logic [31:0] r_w, s_w;
  logic        busy_a, busy_z, busy_w;

  register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) dut_a (
    .clk(clk), .reset(rst), .W(w0), .W_Adr(wa0), .we_pulse(we0),
    .R_Adr(ra0), .S_Adr(sa0), .clr_req(clr0), .R(r_a), .S(s_a), .busy(busy_a));

  register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1)) dut_z (
    .clk(clk), .reset(rst), .W(w0), .W_Adr(wa0), .we_pulse(we0),
    .R_Adr(ra0), .S_Adr(sa0), .clr_req(clr0), .R(r_z), .S(s_z), .busy(busy_z));

  register_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(0)) dut_w (
    .clk(clk), .reset(rst), .W(w1), .W_Adr(wa1), .we_pulse(we1),
    .R_Adr(ra1), .S_Adr(sa1), .clr_req(clr1), .R(r_w), .S(s_w), .busy(busy_w));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0: dut_a, 1: dut_z, 2: dut_w. A sweep is modelled as a counter of
  // entries already zeroed; the model owns no notion of the RTL's encoding.
  logic [31:0] m_mem [3][32];
  bit          m_act [3];
  int          m_idx [3];
  logic [31:0] m_r [3];
  logic [31:0] m_s [3];
  bit          m_busy [3];

  task automatic model_step(input int d, input logic rs, input logic we_i,
                            input int wa_i, input logic [31:0] w_i,
                            input int ra_i, input int sa_i, input logic clr_i,
                            input bit z, input int depth);
    bit acc;
    if (rs) begin
      for (int j = 0; j < 32; j++) m_mem[d][j] = '0;
      m_r[d] = '0;
      m_s[d] = '0;
      m_act[d] = 0;
      m_idx[d] = 0;
    end else begin
      acc = we_i && !m_act[d] && !(z && wa_i == 0);
      m_r[d] = (z && ra_i == 0) ? 32'h0 : (acc && wa_i == ra_i) ? w_i : m_mem[d][ra_i];
      m_s[d] = (z && sa_i == 0) ? 32'h0 : (acc && wa_i == sa_i) ? w_i : m_mem[d][sa_i];
      if (m_act[d]) begin
        m_mem[d][m_idx[d]] = '0;
        m_idx[d]++;
        if (m_idx[d] == depth) m_act[d] = 0;
      end else if (clr_i) begin
        m_act[d] = 1;
        m_idx[d] = 0;
      end
      if (acc) m_mem[d][wa_i] = w_i;
    end
    m_busy[d] = m_act[d];
  endtask

  // compare process: every cycle, #1 after the edge
  always @(posedge clk) begin
    model_step(0, rst, we0, int'(wa0), {16'h0, w0}, int'(ra0), int'(sa0), clr0, 1'b0, 8);
    model_step(1, rst, we0, int'(wa0), {16'h0, w0}, int'(ra0), int'(sa0), clr0, 1'b1, 8);
    model_step(2, rst, we1, int'(wa1), w1, int'(ra1), int'(sa1), clr1, 1'b0, 32);
    #1;
    chk("a_R", {16'h0, r_a}, m_r[0]);
    chk("a_S", {16'h0, s_a}, m_s[0]);
    chk("a_busy", {31'h0, busy_a}, {31'h0, m_busy[0]});
    chk("z_R", {16'h0, r_z}, m_r[1]);
    chk("z_S", {16'h0, s_z}, m_s[1]);
    chk("z_busy", {31'h0, busy_z}, {31'h0, m_busy[1]});
    chk("w_R", r_w, m_r[2]);
    chk("w_S", s_w, m_s[2]);
    chk("w_busy", {31'h0, busy_w}, {31'h0, m_busy[2]});
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int bc;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_R", {16'h0, r_a}, 32'h0);
    chk("rst_busy", {31'h0, busy_a}, 32'h0);
    chk("rst_w_R", r_w, 32'h0);

    // 1: empty read, then write / read-back
    sa0 = 3'd3; cyc();
    chk("t1_S_empty", {16'h0, s_a}, 32'h0);
    we0 = 1'b1; wa0 = 3'd3; w0 = 16'hA5A5; ra0 = 3'd0; cyc();
    we0 = 1'b0; ra0 = 3'd3; cyc();
    chk("t1_R", {16'h0, r_a}, 32'h0000A5A5);

    // 2: same-cycle bypass on both ports
    we0 = 1'b1; wa0 = 3'd5; w0 = 16'h1234; ra0 = 3'd5; sa0 = 3'd5; cyc();
    we0 = 1'b0;
    chk("t2_R", {16'h0, r_a}, 32'h00001234);
    chk("t2_S", {16'h0, s_a}, 32'h00001234);

    // 3: write to r0, zero vs non-zero variant (second write also tries bypass)
    we0 = 1'b1; wa0 = 3'd0; w0 = 16'hFFFF; ra0 = 3'd1; sa0 = 3'd0; cyc();
    chk("t3_z_S_bypass", {16'h0, s_z}, 32'h0);
    chk("t3_a_S_bypass", {16'h0, s_a}, 32'h0000FFFF);
    we0 = 1'b0; ra0 = 3'd0; cyc();
    chk("t3_a_R", {16'h0, r_a}, 32'h0000FFFF);
    chk("t3_z_R", {16'h0, r_z}, 32'h0);

    // 4: fill, clear, lost write during busy
    for (int k = 0; k < 8; k++) begin
      we0 = 1'b1; wa0 = 3'(k); w0 = 16'(16'h0101 * k); cyc();
    end
    we0 = 1'b0; clr0 = 1'b1; cyc();
    clr0 = 1'b0; we0 = 1'b1; wa0 = 3'd2; w0 = 16'hBEEF; ra0 = 3'd7;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy_a) break;
      bc++;
      if (bc == 3) chk("t4_r7_busy3", {16'h0, r_a}, 32'h00000707);
      cyc();
      we0 = 1'b0;
    end
    chk("t4_busy_len", 32'(bc), 32'd8);
    sa0 = 3'd2; cyc();
    chk("t4_r7_after", {16'h0, r_a}, 32'h0);
    chk("t4_lost_write", {16'h0, s_a}, 32'h0);

    // held clr_req: back-to-back sweeps
    for (int k = 0; k < 8; k++) begin
      we0 = 1'b1; wa0 = 3'(k); w0 = 16'(16'h1111 * (k + 1)); ra0 = 3'(k); cyc();
    end
    we0 = 1'b0; clr0 = 1'b1;
    repeat (20) cyc();
    clr0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_a) break;
      cyc();
    end
    chk("held_busy_drop", {31'h0, busy_a}, 32'h0);

    // 5: reset aborts a sweep
    for (int k = 0; k < 8; k++) begin
      we0 = 1'b1; wa0 = 3'(k); w0 = 16'(16'h1111 * (k + 1)); cyc();
    end
    we0 = 1'b0; clr0 = 1'b1; cyc();
    clr0 = 1'b0; cyc(); cyc();
    rst = 1'b1; cyc();
    rst = 1'b0;
    chk("t5_busy", {31'h0, busy_a}, 32'h0);
    for (int k = 0; k < 8; k++) begin
      ra0 = 3'(k); sa0 = 3'(7 - k); cyc();
      chk("t5_R_zero", {16'h0, r_a}, 32'h0);
    end

    // 6: wide/deep instance
    we1 = 1'b1; wa1 = 5'd31; w1 = 32'hDEADBEEF; cyc();
    we1 = 1'b0; ra1 = 5'd31; cyc();
    chk("t6_R", r_w, 32'hDEADBEEF);
    clr1 = 1'b1; cyc();
    clr1 = 1'b0;
    bc = 0;
    for (int i = 0; i < 50; i++) begin
      if (!busy_w) break;
      bc++;
      cyc();
    end
    chk("t6_busy_len", 32'(bc), 32'd32);
    cyc();
    chk("t6_R_after", r_w, 32'h0);

    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
